// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: the datapath width, the canonical NOP, and the
// {pc, instr} entry type carried from fetch to decode.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push/pop/flush. A push and a pop on a full
// FIFO both take effect. Flush wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures the combinational instr_mem word
// and queues {pc, instr} toward decode; redirects flush and restart fetch.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    logic [XLEN-1:0] pc;
    logic            deq;
    logic            enq;
    logic            full;
    logic            empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign deq = if_valid & if_ready;
    // A dequeue frees a slot in the same cycle, so a full queue keeps streaming.
    assign enq = ~redirect_valid & (~full | deq);

    assign wr_entry.pc    = pc;
    assign wr_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enq),
        .pop   (deq),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (enq) begin
            pc <= pc + 32'd4;
        end
    end

    assign imem_addr = pc;
    assign if_valid  = ~empty;
    assign if_instr  = if_valid ? head.instr : NOP_INSTR;
    assign if_pc     = if_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic compared
// against a queue-based reference model of the fetch stage.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int failures = 0;

    logic [63:0] q[$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0011;
            32'h4:   return 32'h0000_0022;
            32'h8:   return 32'h0000_0033;
            default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_rdata = memfn(imem_addr);

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs with the model at the falling edge, apply
    // inputs, then advance the model at the rising edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [63:0] head;
        logic        exp_v;
        logic        deq;
        @(negedge clk);
        exp_v = (q.size() != 0);
        head  = exp_v ? q[0] : {32'h0, NOP};
        chk("m_valid", {31'h0, if_valid}, {31'h0, exp_v});
        chk("m_pc", if_pc, head[63:32]);
        chk("m_instr", if_instr, head[31:0]);
        chk("m_addr", imem_addr, mpc);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        @(posedge clk);
        deq = exp_v && rdy;
        if (rv) begin
            q.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            if (deq) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                q.push_back({mpc, memfn(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        q.delete();
        mpc = RESET_PC;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1;
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);

        // Streaming from reset
        do_reset();
        chk("rel_valid0", {31'h0, if_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        #1 chk("rise_valid", {31'h0, if_valid}, 32'h1);
        chk("seq0_pc", if_pc, 32'h0);
        chk("seq0_instr", if_instr, 32'h11);
        step(1'b0, 32'h0, 1'b1);
        #1 chk("seq1_pc", if_pc, 32'h4);
        chk("seq1_instr", if_instr, 32'h22);
        step(1'b0, 32'h0, 1'b1);
        #1 chk("seq2_pc", if_pc, 32'h8);
        chk("seq2_instr", if_instr, 32'h33);

        // Backpressure from reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0);
            #1 chk("bp_head", if_pc, 32'h0);
            if (i >= 1) chk("bp_addr", imem_addr, 32'h8);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            #1 chk("bp_deliver", if_pc, 32'(i * 4));
        end

        // Redirect while full
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h40, 1'b0);
        #1 chk("rd_valid0", {31'h0, if_valid}, 32'h0);
        chk("rd_addr", imem_addr, 32'h40);
        step(1'b0, 32'h0, 1'b0);
        #1 chk("rd_head", if_pc, 32'h40);
        chk("rd_instr", if_instr, memfn(32'h40));

        // Misaligned redirect target
        step(1'b1, 32'h43, 1'b1);
        #1 chk("mis_addr", imem_addr, 32'h40);
        step(1'b0, 32'h0, 1'b1);
        #1 chk("mis_head", if_pc, 32'h40);

        // PC wrap
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        #1 chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_head", if_pc, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset with a full queue
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_instr", if_instr, NOP);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_pc", if_pc, 32'h0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
